// File: rtl/dispatch_nway_pkg.sv
// Shared types and default sizing for the N-way dispatch stage.
// dispatchStruct : one renamed instruction as presented to dispatch.
// rsEntry        : one RS/ROB allocation line produced by dispatch.
// The struct field widths come from the *_DEF constants, so a dispatch_nway
// instance should keep its parameters equal to these defaults.
package dispatch_nway_pkg;

   localparam int WIDTH_DEF     = 2;
   localparam int NUM_ALU_DEF   = 2;
   localparam int ROB_DEPTH_DEF = 16;
   localparam int NUM_PREGS_DEF = 64;
   localparam int NUM_WAKE_DEF  = 2;

   localparam int PREG_W = $clog2(NUM_PREGS_DEF);
   localparam int ROB_W  = $clog2(ROB_DEPTH_DEF);
   localparam int FU_W   = $clog2(NUM_ALU_DEF + 1);

   typedef struct packed {
      logic [PREG_W-1:0] rs1;
      logic [PREG_W-1:0] rs2;
      logic [PREG_W-1:0] rd;
      logic              RegWrite;
      logic              ALUSrc;
      logic              MemRead;
      logic              MemWrite;
      logic              MemtoReg;
      logic [3:0]        ALUOp;
      logic [15:0]       imm;
   } dispatchStruct;

   typedef struct packed {
      logic             valid;
      logic [ROB_W-1:0] robNum;
      logic [FU_W-1:0]  fu;
      logic             src1rdy;
      logic             src2rdy;
      dispatchStruct    insn;
   } rsEntry;

   // Any memory-side control bit routes the op to the memory unit.
   function automatic logic is_mem_op(input dispatchStruct d);
      return d.MemRead | d.MemWrite | d.MemtoReg;
   endfunction

endpackage

// File: rtl/dispatch_fu_alloc.sv
// Combinational round-robin functional-unit assigner.
// Ports:
//   rr      in   round-robin pointer (next ALU to hand out)
//   mem     in   per-slot memory-op flag
//   valid   in   per-slot valid
//   fu      out  per-slot FU code (NUM_ALU = memory unit, 0 for idle slots)
//   alu_cnt out  number of valid ALU ops in the group
module dispatch_fu_alloc
   import dispatch_nway_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int NUM_ALU = NUM_ALU_DEF,
   parameter int FU_AW   = $clog2(NUM_ALU + 1),
   parameter int K_W     = $clog2(WIDTH + 1)
) (
   input  logic [FU_AW-1:0]            rr,
   input  logic [WIDTH-1:0]            mem,
   input  logic [WIDTH-1:0]            valid,
   output logic [WIDTH-1:0][FU_AW-1:0] fu,
   output logic [K_W-1:0]              alu_cnt
);

   always_comb begin
      int m;
      m  = 0;
      fu = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (valid[i]) begin
            if (mem[i]) begin
               fu[i] = FU_AW'(NUM_ALU);
            end else begin
               // m counts ALU ops already placed earlier in this group
               fu[i] = FU_AW'((int'(rr) + m) % NUM_ALU);
               m++;
            end
         end
      end
      alu_cnt = K_W'(m);
   end

endmodule

// File: rtl/dispatch_nway.sv
// N-way in-order dispatch: allocates ROB/RS lines for a group of renamed
// instructions, tracks ROB occupancy and the physical register ready table,
// and assigns functional units round-robin.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   in_valid     per-slot valid, packed low
//   in_insn      per-slot renamed instruction
//   in_ready     whole group fits in ROB and RS this cycle
//   rs_free      free RS entries
//   retire_cnt   ROB entries retired this cycle
//   wake_valid   completion broadcast valid per wake port
//   wake_preg    completion broadcast physical register per wake port
//   rsLine       per-slot allocation line (zero when slot not dispatched)
//   phy_reg_rdy  physical register ready table
//   rob_count    ROB occupancy
module dispatch_nway
   import dispatch_nway_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEF,
   parameter int NUM_ALU   = NUM_ALU_DEF,
   parameter int ROB_DEPTH = ROB_DEPTH_DEF,
   parameter int NUM_PREGS = NUM_PREGS_DEF,
   parameter int NUM_WAKE  = NUM_WAKE_DEF
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic [WIDTH-1:0]                        in_valid,
   input  dispatchStruct [WIDTH-1:0]               in_insn,
   output logic                                    in_ready,
   input  logic [$clog2(ROB_DEPTH):0]              rs_free,
   input  logic [$clog2(WIDTH+1)-1:0]              retire_cnt,
   input  logic [NUM_WAKE-1:0]                     wake_valid,
   input  logic [NUM_WAKE-1:0][$clog2(NUM_PREGS)-1:0] wake_preg,
   output rsEntry [WIDTH-1:0]                      rsLine,
   output logic [NUM_PREGS-1:0]                    phy_reg_rdy,
   output logic [$clog2(ROB_DEPTH):0]              rob_count
);

   localparam int ROB_AW = $clog2(ROB_DEPTH);
   localparam int CNT_W  = ROB_AW + 1;
   localparam int FU_AW  = $clog2(NUM_ALU + 1);
   localparam int K_W    = $clog2(WIDTH + 1);

   logic [ROB_AW-1:0]            tail;
   logic [FU_AW-1:0]             rr;
   logic [FU_AW-1:0]             rr_nxt;
   logic [K_W-1:0]               k;
   logic [K_W-1:0]               alu_cnt;
   logic                         fire;
   logic [WIDTH-1:0]             mem;
   logic [WIDTH-1:0][FU_AW-1:0]  fu_code;
   logic [CNT_W-1:0]             cnt_nxt;
   logic [NUM_PREGS-1:0]         rdy_nxt;

   always_comb begin
      k   = '0;
      mem = '0;
      for (int i = 0; i < WIDTH; i++) begin
         k      = k + K_W'(in_valid[i]);
         mem[i] = is_mem_op(in_insn[i]);
      end
   end

   assign in_ready = ((ROB_DEPTH - int'(rob_count)) >= int'(k)) &&
                     (int'(rs_free) >= int'(k));
   assign fire     = in_valid[0] & in_ready;

   dispatch_fu_alloc #(
      .WIDTH   (WIDTH),
      .NUM_ALU (NUM_ALU),
      .FU_AW   (FU_AW),
      .K_W     (K_W)
   ) u_fu_alloc (
      .rr      (rr),
      .mem     (mem),
      .valid   (in_valid),
      .fu      (fu_code),
      .alu_cnt (alu_cnt)
   );

   assign rr_nxt  = FU_AW'((int'(rr) + int'(alu_cnt)) % NUM_ALU);
   assign cnt_nxt = CNT_W'(int'(rob_count) + (fire ? int'(k) : 0) - int'(retire_cnt));

   // Allocation lines. Source readiness = table OR same-cycle wakeup, then an
   // older slot in the same group writing that source forces not-ready (its
   // value cannot exist yet, whatever the wake ports say).
   always_comb begin
      logic s1;
      logic s2;
      rsLine = '0;
      s1     = 1'b0;
      s2     = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         s1 = phy_reg_rdy[in_insn[i].rs1];
         s2 = phy_reg_rdy[in_insn[i].rs2];
         for (int w = 0; w < NUM_WAKE; w++) begin
            if (wake_valid[w] && (wake_preg[w] == in_insn[i].rs1)) s1 = 1'b1;
            if (wake_valid[w] && (wake_preg[w] == in_insn[i].rs2)) s2 = 1'b1;
         end
         for (int j = 0; j < i; j++) begin
            if (in_valid[j] && in_insn[j].RegWrite && (in_insn[j].rd != '0)) begin
               if (in_insn[j].rd == in_insn[i].rs1) s1 = 1'b0;
               if (in_insn[j].rd == in_insn[i].rs2) s2 = 1'b0;
            end
         end
         // Immediate operand: rs2 is not read at all.
         if (in_insn[i].ALUSrc) s2 = 1'b1;
         if (fire && in_valid[i]) begin
            rsLine[i].valid   = 1'b1;
            rsLine[i].robNum  = ROB_W'(tail + ROB_AW'(i));
            rsLine[i].fu      = FU_W'(fu_code[i]);
            rsLine[i].src1rdy = s1;
            rsLine[i].src2rdy = s2;
            rsLine[i].insn    = in_insn[i];
         end
      end
   end

   // Wakeups set first, dispatch clears applied after so a clear wins.
   always_comb begin
      rdy_nxt = phy_reg_rdy;
      for (int w = 0; w < NUM_WAKE; w++) begin
         if (wake_valid[w]) rdy_nxt[wake_preg[w]] = 1'b1;
      end
      if (fire) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (in_valid[i] && in_insn[i].RegWrite && (in_insn[i].rd != '0)) begin
               rdy_nxt[in_insn[i].rd] = 1'b0;
            end
         end
      end
      rdy_nxt[0] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tail        <= '0;
         rr          <= '0;
         rob_count   <= '0;
         phy_reg_rdy <= '1;
      end else begin
         assert (int'(retire_cnt) <= int'(rob_count));
         if (fire) begin
            tail <= tail + ROB_AW'(k);
            rr   <= rr_nxt;
         end
         rob_count   <= cnt_nxt;
         phy_reg_rdy <= rdy_nxt;
      end
   end

endmodule

// File: tb/tb_dispatch_nway.sv
// Self-checking bench for dispatch_nway (WIDTH=2, NUM_ALU=2, ROB_DEPTH=16).
// Expected allocation lines are queued when a group is driven and popped
// when rsLine is sampled.
module tb_dispatch_nway;
   import dispatch_nway_pkg::*;

   logic                 clk;
   logic                 reset;
   logic [1:0]           in_valid;
   dispatchStruct [1:0]  in_insn;
   logic                 in_ready;
   logic [4:0]           rs_free;
   logic [1:0]           retire_cnt;
   logic [1:0]           wake_valid;
   logic [1:0][5:0]      wake_preg;
   rsEntry [1:0]         rsLine;
   logic [63:0]          phy_reg_rdy;
   logic [4:0]           rob_count;

   int     errors = 0;
   int     checks = 0;
   rsEntry exp_q[$];

   dispatch_nway #(
      .WIDTH(2), .NUM_ALU(2), .ROB_DEPTH(16), .NUM_PREGS(64), .NUM_WAKE(2)
   ) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_insn(in_insn),
      .in_ready(in_ready), .rs_free(rs_free), .retire_cnt(retire_cnt),
      .wake_valid(wake_valid), .wake_preg(wake_preg), .rsLine(rsLine),
      .phy_reg_rdy(phy_reg_rdy), .rob_count(rob_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic dispatchStruct mk(input int rd, input int rs1, input int rs2,
                                        input logic rw, input logic asrc,
                                        input logic mr, input logic mw, input logic m2r);
      dispatchStruct d;
      d          = '0;
      d.rd       = PREG_W'(rd);
      d.rs1      = PREG_W'(rs1);
      d.rs2      = PREG_W'(rs2);
      d.RegWrite = rw;
      d.ALUSrc   = asrc;
      d.MemRead  = mr;
      d.MemWrite = mw;
      d.MemtoReg = m2r;
      d.ALUOp    = 4'h2;
      d.imm      = 16'(rd * 3 + 1);
      return d;
   endfunction

   function automatic rsEntry ent(input dispatchStruct d, input int rob, input int fu,
                                  input logic s1, input logic s2);
      rsEntry e;
      e         = '0;
      e.valid   = 1'b1;
      e.robNum  = ROB_W'(rob);
      e.fu      = FU_W'(fu);
      e.src1rdy = s1;
      e.src2rdy = s2;
      e.insn    = d;
      return e;
   endfunction

   task automatic drive(input logic [1:0] v, input dispatchStruct a, input dispatchStruct b,
                        input logic [1:0] ret, input logic [1:0] wv,
                        input logic [5:0] w0, input logic [5:0] w1);
      @(negedge clk);
      in_valid     = v;
      in_insn[0]   = a;
      in_insn[1]   = b;
      retire_cnt   = ret;
      wake_valid   = wv;
      wake_preg[0] = w0;
      wake_preg[1] = w1;
      #1;
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
      in_valid   = '0;
      retire_cnt = '0;
      wake_valid = '0;
      reset      = 1'b0;
   endtask

   task automatic test_reset();
      rsEntry e;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (rob_count !== 5'd0) begin errors++; $display("FAIL reset rob_count got %0d want 0", rob_count); end
      checks++;
      if (phy_reg_rdy !== {64{1'b1}}) begin errors++; $display("FAIL reset phy_reg_rdy got %h want all ones", phy_reg_rdy); end
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got %b want 1", in_ready); end
      exp_q.push_back('0);
      exp_q.push_back('0);
      for (int i = 0; i < 2; i++) begin
         e = exp_q.pop_front();
         checks++;
         if (rsLine[i] !== e) begin errors++; $display("FAIL reset rsLine[%0d] got %h want %h", i, rsLine[i], e); end
      end
   endtask

   task automatic test_two_alu();
      dispatchStruct a, b;
      rsEntry e;
      a = mk(5, 1, 2, 1, 0, 0, 0, 0);
      b = mk(6, 3, 4, 1, 0, 0, 0, 0);
      exp_q.push_back(ent(a, 0, 0, 1, 1));
      exp_q.push_back(ent(b, 1, 1, 1, 1));
      drive(2'b11, a, b, 2'd0, 2'b00, 6'd0, 6'd0);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL two_alu in_ready got %b want 1", in_ready); end
      for (int i = 0; i < 2; i++) begin
         e = exp_q.pop_front();
         checks++;
         if (rsLine[i] !== e) begin errors++; $display("FAIL two_alu rsLine[%0d] got %h want %h", i, rsLine[i], e); end
      end
      settle();
      checks++;
      if (rob_count !== 5'd2) begin errors++; $display("FAIL two_alu rob_count got %0d want 2", rob_count); end
      checks++;
      if (phy_reg_rdy[6:5] !== 2'b00) begin errors++; $display("FAIL two_alu rdy[6:5] got %b want 00", phy_reg_rdy[6:5]); end
   endtask

   task automatic test_intra_dep();
      dispatchStruct a, b;
      rsEntry e;
      a = mk(7, 1, 2, 1, 0, 0, 0, 0);
      b = mk(0, 7, 8, 0, 0, 0, 0, 0);
      exp_q.push_back(ent(a, 2, 0, 1, 1));
      exp_q.push_back(ent(b, 3, 1, 0, 1));
      drive(2'b11, a, b, 2'd0, 2'b01, 6'd7, 6'd0);
      for (int i = 0; i < 2; i++) begin
         e = exp_q.pop_front();
         checks++;
         if (rsLine[i] !== e) begin errors++; $display("FAIL intra_dep rsLine[%0d] got %h want %h", i, rsLine[i], e); end
      end
      settle();
      checks++;
      if (phy_reg_rdy[7] !== 1'b0) begin errors++; $display("FAIL intra_dep rdy[7] got %b want 0", phy_reg_rdy[7]); end
      checks++;
      if (rob_count !== 5'd4) begin errors++; $display("FAIL intra_dep rob_count got %0d want 4", rob_count); end
   endtask

   task automatic test_wake_clear();
      dispatchStruct a, b, z;
      rsEntry e;
      z = mk(0, 0, 0, 0, 0, 0, 0, 0);
      a = mk(9, 1, 2, 1, 0, 0, 0, 0);
      exp_q.push_back(ent(a, 4, 0, 1, 1));
      exp_q.push_back('0);
      drive(2'b01, a, z, 2'd0, 2'b11, 6'd9, 6'd5);
      for (int i = 0; i < 2; i++) begin
         e = exp_q.pop_front();
         checks++;
         if (rsLine[i] !== e) begin errors++; $display("FAIL wake_clear rsLine[%0d] got %h want %h", i, rsLine[i], e); end
      end
      settle();
      checks++;
      if (phy_reg_rdy[9] !== 1'b0) begin errors++; $display("FAIL wake_clear rdy[9] got %b want 0", phy_reg_rdy[9]); end
      checks++;
      if (phy_reg_rdy[5] !== 1'b1) begin errors++; $display("FAIL wake_clear rdy[5] got %b want 1", phy_reg_rdy[5]); end
      // wake only, no group
      exp_q.push_back('0);
      drive(2'b00, z, z, 2'd0, 2'b01, 6'd9, 6'd0);
      e = exp_q.pop_front();
      checks++;
      if (rsLine[0] !== e) begin errors++; $display("FAIL wake_idle rsLine[0] got %h want %h", rsLine[0], e); end
      settle();
      checks++;
      if (phy_reg_rdy[9] !== 1'b1) begin errors++; $display("FAIL wake_idle rdy[9] got %b want 1", phy_reg_rdy[9]); end
      checks++;
      if (rob_count !== 5'd5) begin errors++; $display("FAIL wake_idle rob_count got %0d want 5", rob_count); end
      // rr is 1 now; slot1 uses an immediate so rs2=p6 (busy) is ignored
      a = mk(10, 9, 6, 1, 0, 0, 0, 0);
      b = mk(0, 0, 6, 0, 1, 0, 0, 0);
      exp_q.push_back(ent(a, 5, 1, 1, 0));
      exp_q.push_back(ent(b, 6, 0, 1, 1));
      drive(2'b11, a, b, 2'd0, 2'b00, 6'd0, 6'd0);
      for (int i = 0; i < 2; i++) begin
         e = exp_q.pop_front();
         checks++;
         if (rsLine[i] !== e) begin errors++; $display("FAIL read_p9 rsLine[%0d] got %h want %h", i, rsLine[i], e); end
      end
      settle();
   endtask

   task automatic test_mem_rr();
      dispatchStruct a, b;
      rsEntry e;
      a = mk(11, 1, 0, 1, 1, 1, 0, 1);
      b = mk(12, 2, 3, 1, 0, 0, 0, 0);
      exp_q.push_back(ent(a, 7, 2, 1, 1));
      exp_q.push_back(ent(b, 8, 1, 1, 1));
      drive(2'b11, a, b, 2'd0, 2'b00, 6'd0, 6'd0);
      for (int i = 0; i < 2; i++) begin
         e = exp_q.pop_front();
         checks++;
         if (rsLine[i] !== e) begin errors++; $display("FAIL mem_rr rsLine[%0d] got %h want %h", i, rsLine[i], e); end
      end
      settle();
      checks++;
      if (rob_count !== 5'd9) begin errors++; $display("FAIL mem_rr rob_count got %0d want 9", rob_count); end
   endtask

   task automatic test_full_wrap();
      dispatchStruct a, b, z;
      rsEntry e;
      z = mk(0, 0, 0, 0, 0, 0, 0, 0);
      // rr is back to 0, so two-ALU groups keep it there
      for (int g = 0; g < 3; g++) begin
         exp_q.push_back(ent(z, 9 + 2 * g, 0, 1, 1));
         exp_q.push_back(ent(z, 10 + 2 * g, 1, 1, 1));
         drive(2'b11, z, z, 2'd0, 2'b00, 6'd0, 6'd0);
         for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (rsLine[i] !== e) begin errors++; $display("FAIL fill rsLine[%0d] got %h want %h", i, rsLine[i], e); end
         end
         settle();
      end
      checks++;
      if (rob_count !== 5'd15) begin errors++; $display("FAIL fill rob_count got %0d want 15", rob_count); end
      a = mk(20, 1, 2, 1, 0, 0, 0, 0);
      b = mk(21, 20, 3, 1, 0, 0, 0, 0);
      for (int r = 0; r < 2; r++) begin
         exp_q.push_back('0);
         exp_q.push_back('0);
         drive(2'b11, a, b, 2'(r), 2'b00, 6'd0, 6'd0);
         checks++;
         if (in_ready !== 1'b0) begin errors++; $display("FAIL full in_ready retire=%0d got %b want 0", r, in_ready); end
         for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (rsLine[i] !== e) begin errors++; $display("FAIL full rsLine[%0d] got %h want %h", i, rsLine[i], e); end
         end
         settle();
         checks++;
         if (rob_count !== 5'(15 - r)) begin errors++; $display("FAIL full rob_count got %0d want %0d", rob_count, 15 - r); end
         checks++;
         if (phy_reg_rdy[20] !== 1'b1) begin errors++; $display("FAIL full rdy[20] got %b want 1", phy_reg_rdy[20]); end
      end
      // count 14, tail 15: group wraps the ROB; retire 2 in the same cycle
      exp_q.push_back(ent(a, 15, 0, 1, 1));
      exp_q.push_back(ent(b, 0, 1, 0, 1));
      drive(2'b11, a, b, 2'd2, 2'b00, 6'd0, 6'd0);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL wrap in_ready got %b want 1", in_ready); end
      for (int i = 0; i < 2; i++) begin
         e = exp_q.pop_front();
         checks++;
         if (rsLine[i] !== e) begin errors++; $display("FAIL wrap rsLine[%0d] got %h want %h", i, rsLine[i], e); end
      end
      settle();
      checks++;
      if (rob_count !== 5'd14) begin errors++; $display("FAIL wrap rob_count got %0d want 14", rob_count); end
      checks++;
      if (phy_reg_rdy[21:20] !== 2'b00) begin errors++; $display("FAIL wrap rdy[21:20] got %b want 00", phy_reg_rdy[21:20]); end
   endtask

   task automatic test_rs_free();
      dispatchStruct a, b;
      rsEntry e;
      a = mk(22, 0, 0, 1, 0, 0, 0, 0);
      b = mk(23, 0, 0, 1, 0, 0, 0, 0);
      rs_free = 5'd1;
      exp_q.push_back('0);
      exp_q.push_back('0);
      drive(2'b11, a, b, 2'd0, 2'b00, 6'd0, 6'd0);
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL rs_free k2 in_ready got %b want 0", in_ready); end
      for (int i = 0; i < 2; i++) begin
         e = exp_q.pop_front();
         checks++;
         if (rsLine[i] !== e) begin errors++; $display("FAIL rs_free k2 rsLine[%0d] got %h want %h", i, rsLine[i], e); end
      end
      settle();
      exp_q.push_back(ent(a, 1, 0, 1, 1));
      exp_q.push_back('0);
      drive(2'b01, a, b, 2'd0, 2'b00, 6'd0, 6'd0);
      for (int i = 0; i < 2; i++) begin
         e = exp_q.pop_front();
         checks++;
         if (rsLine[i] !== e) begin errors++; $display("FAIL rs_free k1 rsLine[%0d] got %h want %h", i, rsLine[i], e); end
      end
      settle();
      rs_free = 5'd16;
      checks++;
      if (rob_count !== 5'd15) begin errors++; $display("FAIL rs_free rob_count got %0d want 15", rob_count); end
      // retire only
      drive(2'b00, a, b, 2'd2, 2'b00, 6'd0, 6'd0);
      settle();
      checks++;
      if (rob_count !== 5'd13) begin errors++; $display("FAIL retire rob_count got %0d want 13", rob_count); end
   endtask

   task automatic test_reset_mid();
      dispatchStruct a, b;
      rsEntry e;
      a = mk(24, 1, 2, 1, 0, 0, 0, 0);
      b = mk(25, 3, 4, 1, 0, 0, 0, 0);
      reset = 1'b1;
      drive(2'b11, a, b, 2'd1, 2'b11, 6'd30, 6'd31);
      settle();
      checks++;
      if (rob_count !== 5'd0) begin errors++; $display("FAIL reset_mid rob_count got %0d want 0", rob_count); end
      checks++;
      if (phy_reg_rdy !== {64{1'b1}}) begin errors++; $display("FAIL reset_mid phy_reg_rdy got %h want all ones", phy_reg_rdy); end
      // rr was 1 before reset; tail was 2
      exp_q.push_back(ent(b, 0, 0, 1, 1));
      exp_q.push_back('0);
      drive(2'b01, b, a, 2'd0, 2'b00, 6'd0, 6'd0);
      for (int i = 0; i < 2; i++) begin
         e = exp_q.pop_front();
         checks++;
         if (rsLine[i] !== e) begin errors++; $display("FAIL reset_mid rsLine[%0d] got %h want %h", i, rsLine[i], e); end
      end
      settle();
      checks++;
      if (rob_count !== 5'd1) begin errors++; $display("FAIL reset_mid after rob_count got %0d want 1", rob_count); end
   endtask

   initial begin
      reset      = 1'b1;
      in_valid   = '0;
      in_insn    = '0;
      rs_free    = 5'd16;
      retire_cnt = '0;
      wake_valid = '0;
      wake_preg  = '0;
      test_reset();
      test_two_alu();
      test_intra_dep();
      test_wake_clear();
      test_mem_rr();
      test_full_wrap();
      test_rs_free();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
